gemm_tile_sequencer: RTL and testbench
======================================

GEMM_TILE_SEQUENCER -- requirements
Module: gemm_tile_sequencer

Interface
REQ-001 Parameter BASE_ADDR, default 32'h9000_0000, system-bus base of the gemm configuration registers.
REQ-002 Parameters BLK_M, default 16, BLK_K, default SUPER_SYS_COLS, and BLK_N, default SUPER_SYS_ROWS, give the maximum tile dimensions.
REQ-003 The block SHALL have one clock, and its reset SHALL be asynchronous and active-high.
REQ-004 clk  in  1  clock.
REQ-005 rst  in  1  asynchronous active-high reset.
REQ-006 cmd_valid  in  1 / cmd_ready  out  1  full-matrix command handshake.
REQ-007 cmd_m, cmd_k, cmd_n  in  16 each  matrix dimensions M, K, N.
REQ-008 cmd_a_addr, cmd_b_addr, cmd_c_addr  in  32 each  matrix base addresses.
REQ-009 bus_en, bus_rdwr (1=write)  out  1 each; bus_addr, bus_wr_data  out  32; bus_rd_data  in  32  gemm system-bus master port.
REQ-010 busy  out  1  command in progress; done  out  1  one-cycle completion pulse.

Function
REQ-011 The command SHALL be accepted on the clk edge where cmd_valid and cmd_ready are both 1, and cmd_ready SHALL be 1 only in IDLE.
REQ-012 Tile order: n SHALL be the outer loop (step BLK_N), m the middle loop (step BLK_M), and k the inner loop (step BLK_K).
REQ-013 Tile sizes: xsize SHALL equal min(BLK_x, X-x); first SHALL equal (k==0); last SHALL equal (k+BLK_K>=K).
REQ-014 Tile addresses SHALL be A=a+k+m*K, B=b+n+k*N+(ksize-1)*N, and C=c+n+m*N, all 32-bit and wrapping modulo 2^32.
REQ-015 Per tile, the block SHALL issue one write per cycle in this order: +12 (A stride =K), +16 (B stride =N), +0 (A), +4 (B), +8 (C), +20 (ctrl = first<<1|last), +24 (dim = msize|ksize<<5|nsize<<10).
REQ-016 After the dim write, state POLL_FULL SHALL drive bus_en=1, rdwr=0 and addr=BASE+0, and SHALL sample bus_rd_data[0] one cycle later.
REQ-017 In POLL_FULL, a sampled value of 1 SHALL repeat the read, and a sampled value of 0 SHALL advance to the next tile's first write.
REQ-018 After the last tile, state POLL_DONE SHALL read BASE+24 until bus_rd_data[0]==1, then pulse done for one cycle and enter IDLE.
REQ-019 The FSM states SHALL be IDLE, WR_ASTR, WR_BSTR, WR_A, WR_B, WR_C, WR_CTRL, WR_DIM, POLL_FULL, ADVANCE, POLL_DONE, and DONE.
REQ-020 The first bus write SHALL occur in the cycle after acceptance, and ADVANCE SHALL take one cycle with bus_en=0.
REQ-021 If M, K or N is 0 at acceptance, the block SHALL generate no bus traffic and SHALL pulse done in the next cycle.
REQ-022 busy SHALL be 1 from the cycle after acceptance through the done cycle inclusive.
REQ-023 Outside write and poll states, bus_en SHALL be 0, and bus_addr and bus_wr_data SHALL hold their last values.
REQ-024 cmd_valid SHALL be ignored while busy, and command fields SHALL be latched at acceptance only.

Reset
REQ-025 On rst, the block SHALL enter IDLE, and bus_en, bus_rdwr, bus_addr, bus_wr_data, busy and done SHALL be 0, with cmd_ready=1.
REQ-026 Reset mid-operation SHALL discard the latched command and tile counters, and no partial write SHALL be completed.

Structure
REQ-027 The shared package SHALL hold the register offset constants (0,4,8,12,16,20,24), the dim field positions (0,5,10), the BLK defaults derived from SUPER_SYS_ROWS/COLS, and the state enum.
REQ-028 One sub-module, gemm_tile_counter, SHALL hold the nested n/m/k counters and SHALL generate msize/ksize/nsize, first, last and final-tile.

Verification
REQ-029 M=K=N=16, a=0, b=256, c=512 -> the block SHALL write 16, 16, 0, 496, 512, 3, 0x4210, then poll, then pulse done once.
REQ-030 M=K=N=20 -> the block SHALL process 8 tiles, and tile 2 SHALL write B=b+380, ctrl=1, dim=0x4090.
REQ-031 gemm full held 1 for 5 reads -> the block SHALL issue no write until the sampled value is 0.
REQ-032 cmd_m=0 -> the block SHALL keep bus_en=0 and SHALL pulse done in the cycle after acceptance.
REQ-033 rst asserted during WR_B -> bus_en=0 and busy=0 SHALL hold immediately, and cmd_ready=1 SHALL hold after release.
REQ-034 cmd_valid=1 with new fields while busy -> the block SHALL not accept the command, and the tile addresses SHALL be unchanged.

Source files
------------

// File: rtl/gemm_tile_sequencer_pkg.sv
// Shared constants and types for the GEMM tile sequencer: register map,
// dim-word field layout, systolic-array-derived tile defaults and FSM states.
package gemm_tile_sequencer_pkg;

    localparam int unsigned SUPER_SYS_ROWS = 16;
    localparam int unsigned SUPER_SYS_COLS = 16;

    localparam int unsigned BLK_M_DEFAULT = 16;
    localparam int unsigned BLK_K_DEFAULT = SUPER_SYS_COLS;
    localparam int unsigned BLK_N_DEFAULT = SUPER_SYS_ROWS;

    // Offset 0 doubles as the "engine full" status, offset 24 as "all done".
    localparam logic [31:0] REG_A_ADDR   = 32'd0;
    localparam logic [31:0] REG_B_ADDR   = 32'd4;
    localparam logic [31:0] REG_C_ADDR   = 32'd8;
    localparam logic [31:0] REG_A_STRIDE = 32'd12;
    localparam logic [31:0] REG_B_STRIDE = 32'd16;
    localparam logic [31:0] REG_CTRL     = 32'd20;
    localparam logic [31:0] REG_DIM      = 32'd24;

    localparam int unsigned DIM_M_POS   = 0;
    localparam int unsigned DIM_K_POS   = 5;
    localparam int unsigned DIM_N_POS   = 10;
    localparam int unsigned DIM_FIELD_W = 5;

    typedef enum logic [3:0] {
        IDLE,
        WR_ASTR,
        WR_BSTR,
        WR_A,
        WR_B,
        WR_C,
        WR_CTRL,
        WR_DIM,
        POLL_FULL,
        ADVANCE,
        POLL_DONE,
        DONE
    } state_t;

endpackage

// File: rtl/gemm_tile_counter.sv
// Nested n (outer) / m (middle) / k (inner) tile counters with per-tile
// sizes and first/last/final-tile flags for the current position.
module gemm_tile_counter
    import gemm_tile_sequencer_pkg::*;
#(
    parameter int unsigned BLK_M = BLK_M_DEFAULT,
    parameter int unsigned BLK_K = BLK_K_DEFAULT,
    parameter int unsigned BLK_N = BLK_N_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        step,
    input  logic [15:0] dim_m,
    input  logic [15:0] dim_k,
    input  logic [15:0] dim_n,
    output logic [15:0] m_idx,
    output logic [15:0] k_idx,
    output logic [15:0] n_idx,
    output logic [15:0] msize,
    output logic [15:0] ksize,
    output logic [15:0] nsize,
    output logic        first,
    output logic        last,
    output logic        final_tile
);

    localparam logic [15:0] BM16 = 16'(BLK_M);
    localparam logic [15:0] BK16 = 16'(BLK_K);
    localparam logic [15:0] BN16 = 16'(BLK_N);

    logic [16:0] m_end, k_end, n_end;
    logic [15:0] m_rem, k_rem, n_rem;
    logic        last_m, last_k, last_n;

    // 17-bit sums so a tile ending at or past 0xFFFF still compares correctly.
    assign m_end = {1'b0, m_idx} + {1'b0, BM16};
    assign k_end = {1'b0, k_idx} + {1'b0, BK16};
    assign n_end = {1'b0, n_idx} + {1'b0, BN16};

    assign last_m = m_end >= {1'b0, dim_m};
    assign last_k = k_end >= {1'b0, dim_k};
    assign last_n = n_end >= {1'b0, dim_n};

    assign m_rem = dim_m - m_idx;
    assign k_rem = dim_k - k_idx;
    assign n_rem = dim_n - n_idx;

    assign msize = (m_rem > BM16) ? BM16 : m_rem;
    assign ksize = (k_rem > BK16) ? BK16 : k_rem;
    assign nsize = (n_rem > BN16) ? BN16 : n_rem;

    assign first      = (k_idx == '0);
    assign last       = last_k;
    assign final_tile = last_k && last_m && last_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_idx <= '0;
            k_idx <= '0;
            n_idx <= '0;
        end else if (load) begin
            m_idx <= '0;
            k_idx <= '0;
            n_idx <= '0;
        end else if (step) begin
            if (!last_k) begin
                k_idx <= k_end[15:0];
            end else begin
                k_idx <= '0;
                if (!last_m) begin
                    m_idx <= m_end[15:0];
                end else begin
                    m_idx <= '0;
                    n_idx <= n_end[15:0];
                end
            end
        end
    end

endmodule

// File: rtl/gemm_tile_sequencer.sv
// Splits a full M x K x N matrix command into tiles and programs each one
// into the GEMM engine over its system-bus register interface.
module gemm_tile_sequencer
    import gemm_tile_sequencer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h9000_0000,
    parameter int unsigned BLK_M     = BLK_M_DEFAULT,
    parameter int unsigned BLK_K     = BLK_K_DEFAULT,
    parameter int unsigned BLK_N     = BLK_N_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [15:0] cmd_m,
    input  logic [15:0] cmd_k,
    input  logic [15:0] cmd_n,
    input  logic [31:0] cmd_a_addr,
    input  logic [31:0] cmd_b_addr,
    input  logic [31:0] cmd_c_addr,
    output logic        bus_en,
    output logic        bus_rdwr,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wr_data,
    input  logic [31:0] bus_rd_data,
    output logic        busy,
    output logic        done
);

    state_t      state, state_next;
    logic        poll_pend;
    logic        accept, cmd_zero, step;
    logic [15:0] m_q, k_q, n_q;
    logic [31:0] a_q, b_q, c_q;
    logic [31:0] addr_hold, data_hold;

    logic [15:0] m_idx, k_idx, n_idx, msize, ksize, nsize;
    logic        first, last, final_tile;
    logic [31:0] a_tile, b_tile, c_tile, ctrl_word, dim_word;
    logic        unused_bits;

    assign accept   = cmd_valid && (state == IDLE);
    assign cmd_zero = (cmd_m == '0) || (cmd_k == '0) || (cmd_n == '0);

    gemm_tile_counter #(
        .BLK_M (BLK_M),
        .BLK_K (BLK_K),
        .BLK_N (BLK_N)
    ) u_counter (
        .clk        (clk),
        .rst        (rst),
        .load       (accept),
        .step       (step),
        .dim_m      (m_q),
        .dim_k      (k_q),
        .dim_n      (n_q),
        .m_idx      (m_idx),
        .k_idx      (k_idx),
        .n_idx      (n_idx),
        .msize      (msize),
        .ksize      (ksize),
        .nsize      (nsize),
        .first      (first),
        .last       (last),
        .final_tile (final_tile)
    );

    // B points at the last row of the k-slice: the engine walks B upwards.
    assign a_tile = a_q + 32'(k_idx) + 32'(m_idx) * 32'(k_q);
    assign b_tile = b_q + 32'(n_idx) + 32'(k_idx) * 32'(n_q)
                  + (32'(ksize) - 32'd1) * 32'(n_q);
    assign c_tile = c_q + 32'(n_idx) + 32'(m_idx) * 32'(n_q);

    assign ctrl_word = {30'd0, first, last};
    assign dim_word  = (32'(msize[DIM_FIELD_W-1:0]) << DIM_M_POS)
                     | (32'(ksize[DIM_FIELD_W-1:0]) << DIM_K_POS)
                     | (32'(nsize[DIM_FIELD_W-1:0]) << DIM_N_POS);

    assign unused_bits = ^{bus_rd_data[31:1], msize[15:DIM_FIELD_W],
                           ksize[15:DIM_FIELD_W], nsize[15:DIM_FIELD_W]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            poll_pend <= 1'b0;
            m_q       <= '0;
            k_q       <= '0;
            n_q       <= '0;
            a_q       <= '0;
            b_q       <= '0;
            c_q       <= '0;
            addr_hold <= '0;
            data_hold <= '0;
        end else begin
            state     <= state_next;
            poll_pend <= (state_next == state) &&
                         ((state == POLL_FULL) || (state == POLL_DONE));
            addr_hold <= bus_addr;
            data_hold <= bus_wr_data;
            if (accept) begin
                m_q <= cmd_m;
                k_q <= cmd_k;
                n_q <= cmd_n;
                a_q <= cmd_a_addr;
                b_q <= cmd_b_addr;
                c_q <= cmd_c_addr;
            end
        end
    end

    // A read is issued every poll cycle; the response is judged one cycle later.
    always_comb begin
        state_next  = state;
        bus_en      = 1'b0;
        bus_rdwr    = 1'b0;
        bus_addr    = addr_hold;
        bus_wr_data = data_hold;
        cmd_ready   = (state == IDLE);
        busy        = (state != IDLE);
        done        = 1'b0;
        step        = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_valid) state_next = cmd_zero ? DONE : WR_ASTR;
            end
            WR_ASTR: begin
                bus_en      = 1'b1;
                bus_rdwr    = 1'b1;
                bus_addr    = BASE_ADDR + REG_A_STRIDE;
                bus_wr_data = 32'(k_q);
                state_next  = WR_BSTR;
            end
            WR_BSTR: begin
                bus_en      = 1'b1;
                bus_rdwr    = 1'b1;
                bus_addr    = BASE_ADDR + REG_B_STRIDE;
                bus_wr_data = 32'(n_q);
                state_next  = WR_A;
            end
            WR_A: begin
                bus_en      = 1'b1;
                bus_rdwr    = 1'b1;
                bus_addr    = BASE_ADDR + REG_A_ADDR;
                bus_wr_data = a_tile;
                state_next  = WR_B;
            end
            WR_B: begin
                bus_en      = 1'b1;
                bus_rdwr    = 1'b1;
                bus_addr    = BASE_ADDR + REG_B_ADDR;
                bus_wr_data = b_tile;
                state_next  = WR_C;
            end
            WR_C: begin
                bus_en      = 1'b1;
                bus_rdwr    = 1'b1;
                bus_addr    = BASE_ADDR + REG_C_ADDR;
                bus_wr_data = c_tile;
                state_next  = WR_CTRL;
            end
            WR_CTRL: begin
                bus_en      = 1'b1;
                bus_rdwr    = 1'b1;
                bus_addr    = BASE_ADDR + REG_CTRL;
                bus_wr_data = ctrl_word;
                state_next  = WR_DIM;
            end
            WR_DIM: begin
                bus_en      = 1'b1;
                bus_rdwr    = 1'b1;
                bus_addr    = BASE_ADDR + REG_DIM;
                bus_wr_data = dim_word;
                state_next  = POLL_FULL;
            end
            POLL_FULL: begin
                bus_en   = 1'b1;
                bus_addr = BASE_ADDR + REG_A_ADDR;
                if (poll_pend && !bus_rd_data[0])
                    state_next = final_tile ? POLL_DONE : ADVANCE;
            end
            ADVANCE: begin
                step       = 1'b1;
                state_next = WR_ASTR;
            end
            POLL_DONE: begin
                bus_en   = 1'b1;
                bus_addr = BASE_ADDR + REG_DIM;
                if (poll_pend && bus_rd_data[0]) state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_gemm_tile_sequencer.sv
// Self-checking bench: a tile-list reference model built from plain nested
// loops, plus a simple engine responder for the full/done status reads.
module tb_gemm_tile_sequencer;

    localparam logic [31:0] BASE = 32'h9000_0000;
    localparam int BM = 16;
    localparam int BK = 16;
    localparam int BN = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [15:0] cmd_m = '0, cmd_k = '0, cmd_n = '0;
    logic [31:0] cmd_a_addr = '0, cmd_b_addr = '0, cmd_c_addr = '0;
    logic        bus_en, bus_rdwr;
    logic [31:0] bus_addr, bus_wr_data;
    logic [31:0] bus_rd_data = '0;
    logic        busy, done;

    int n_assert = 0;
    int n_fail   = 0;

    // Responder state (written only by the responder process)
    int full_rd_total = 0;
    int done_rd_total = 0;
    bit in_full = 1'b0;
    // Thresholds (written only by the stimulus process)
    int full_until = 0;
    int done_until = 0;
    // Monitor state (written only by the monitor process)
    logic [63:0] wr_q[$];
    int done_total   = 0;
    int bus_total    = 0;
    int early_writes = 0;

    gemm_tile_sequencer #(
        .BASE_ADDR (BASE)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_m       (cmd_m),
        .cmd_k       (cmd_k),
        .cmd_n       (cmd_n),
        .cmd_a_addr  (cmd_a_addr),
        .cmd_b_addr  (cmd_b_addr),
        .cmd_c_addr  (cmd_c_addr),
        .bus_en      (bus_en),
        .bus_rdwr    (bus_rdwr),
        .bus_addr    (bus_addr),
        .bus_wr_data (bus_wr_data),
        .bus_rd_data (bus_rd_data),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    // Engine: reports "full" for the configured number of status reads,
    // and "not done" for the configured number of done reads.
    always @(posedge clk) begin
        if (bus_en && !bus_rdwr) begin
            if (bus_addr == BASE) begin
                if (full_rd_total < full_until) begin
                    bus_rd_data <= 32'd1;
                    in_full     <= 1'b1;
                end else begin
                    bus_rd_data <= 32'd0;
                    in_full     <= 1'b0;
                end
                full_rd_total <= full_rd_total + 1;
            end else if (bus_addr == BASE + 32'd24) begin
                bus_rd_data   <= (done_rd_total < done_until) ? 32'd0 : 32'd1;
                done_rd_total <= done_rd_total + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (bus_en) bus_total <= bus_total + 1;
        if (bus_en && bus_rdwr) begin
            wr_q.push_back({bus_addr, bus_wr_data});
            if (in_full) early_writes <= early_writes + 1;
        end
        if (done) done_total <= done_total + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic run_cmd(input logic [15:0] m, input logic [15:0] k, input logic [15:0] n,
                           input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                           input int ones, input int zeros, input bit inject,
                           input string tag, output int wb);
        logic [63:0] exp_q[$];
        logic [31:0] ea, eb, ec, ed;
        int ms, ks, ns, db, bb, ew, cyc;
        bit zero;
        zero = (m == 0) || (k == 0) || (n == 0);
        if (!zero) begin
            for (int nn = 0; nn < int'(n); nn += BN)
                for (int mm = 0; mm < int'(m); mm += BM)
                    for (int kk = 0; kk < int'(k); kk += BK) begin
                        ms = (int'(m) - mm < BM) ? int'(m) - mm : BM;
                        ks = (int'(k) - kk < BK) ? int'(k) - kk : BK;
                        ns = (int'(n) - nn < BN) ? int'(n) - nn : BN;
                        ea = a + 32'(kk) + 32'(mm) * 32'(k);
                        eb = b + 32'(nn) + 32'(kk) * 32'(n) + 32'(ks - 1) * 32'(n);
                        ec = c + 32'(nn) + 32'(mm) * 32'(n);
                        ed = 32'(ms + ks * 32 + ns * 1024);
                        exp_q.push_back({BASE + 32'd12, 32'(k)});
                        exp_q.push_back({BASE + 32'd16, 32'(n)});
                        exp_q.push_back({BASE, ea});
                        exp_q.push_back({BASE + 32'd4, eb});
                        exp_q.push_back({BASE + 32'd8, ec});
                        exp_q.push_back({BASE + 32'd20,
                                         32'((kk == 0 ? 2 : 0) + (kk + BK >= int'(k) ? 1 : 0))});
                        exp_q.push_back({BASE + 32'd24, ed});
                    end
        end
        tick();
        full_until = full_rd_total + ones;
        done_until = done_rd_total + zeros;
        wb = wr_q.size();
        db = done_total;
        bb = bus_total;
        ew = early_writes;
        chk({tag, ".ready"}, 64'(cmd_ready), 64'd1);
        cmd_valid  = 1'b1;
        cmd_m      = m;
        cmd_k      = k;
        cmd_n      = n;
        cmd_a_addr = a;
        cmd_b_addr = b;
        cmd_c_addr = c;
        tick();
        cmd_valid = inject;
        chk({tag, ".busy1"}, 64'(busy), 64'd1);
        if (zero) begin
            chk({tag, ".done_next"}, 64'(done), 64'd1);
            chk({tag, ".no_bus"}, 64'(bus_en), 64'd0);
        end else begin
            chk({tag, ".first_wr"}, {31'd0, bus_en, bus_rdwr, bus_addr}, {31'd0, 2'b11, BASE + 32'd12});
            chk({tag, ".no_done"}, 64'(done), 64'd0);
        end
        cyc = 0;
        while (done_total == db && cyc < 8000) begin
            if (inject && cyc < 8) begin
                cmd_m      = 16'($urandom_range(1, 60));
                cmd_k      = 16'($urandom_range(1, 60));
                cmd_n      = 16'($urandom_range(1, 60));
                cmd_a_addr = $urandom;
                cmd_b_addr = $urandom;
                cmd_c_addr = $urandom;
            end else begin
                cmd_valid = 1'b0;
            end
            tick();
            cyc++;
        end
        cmd_valid = 1'b0;
        chk({tag, ".timeout"}, 64'(done_total > db), 64'd1);
        tick();
        tick();
        tick();
        chk({tag, ".done_once"}, 64'(done_total - db), 64'd1);
        chk({tag, ".idle_busy"}, 64'(busy), 64'd0);
        chk({tag, ".idle_ready"}, 64'(cmd_ready), 64'd1);
        if (zero) chk({tag, ".bus_quiet"}, 64'(bus_total - bb), 64'd0);
        chk({tag, ".nwrites"}, 64'(wr_q.size() - wb), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            chk($sformatf("%s.wr%0d", tag, i), wr_q[wb + i], exp_q[i]);
        chk({tag, ".early_wr"}, 64'(early_writes - ew), 64'd0);
    endtask

    initial begin
        int wb;
        int cyc;
        repeat (3) @(negedge clk);
        #1;
        chk("rst.ready", 64'(cmd_ready), 64'd1);
        chk("rst.outs", {bus_en, bus_rdwr, busy, done, bus_addr, bus_wr_data},
            {4'b0000, 32'd0, 32'd0});
        rst = 1'b0;
        tick();

        // Single 16x16x16 tile
        run_cmd(16, 16, 16, 32'd0, 32'd256, 32'd512, 0, 2, 1'b0, "t16", wb);
        chk("t16.b_const", wr_q[wb + 3], {BASE + 32'd4, 32'd496});
        chk("t16.dim_const", wr_q[wb + 6], {BASE + 32'd24, 32'h4210});

        // 20^3: eight tiles; second tile is the k-remainder
        run_cmd(20, 20, 20, 32'h100, 32'h2000, 32'h8000, 0, 1, 1'b0, "t20", wb);
        chk("t20.b_const", wr_q[wb + 10], {BASE + 32'd4, 32'h2000 + 32'd380});
        chk("t20.ctrl_const", wr_q[wb + 12], {BASE + 32'd20, 32'd1});
        chk("t20.dim_const", wr_q[wb + 13], {BASE + 32'd24, 32'h4090});

        // Engine full for 5 reads
        run_cmd(20, 8, 16, 32'h40, 32'h80, 32'hC0, 5, 0, 1'b0, "full5", wb);

        // Zero dimensions
        run_cmd(0, 16, 16, 32'h1, 32'h2, 32'h3, 0, 0, 1'b0, "m0", wb);
        run_cmd(5, 7, 0, 32'h1, 32'h2, 32'h3, 0, 0, 1'b0, "n0", wb);

        // New command fields presented while busy; address wrap near 2^32
        run_cmd(20, 20, 20, 32'hFFFF_FF00, 32'hFFFF_FFF0, 32'h10, 1, 1, 1'b1, "inject", wb);

        // Reset while the B address write is on the bus
        tick();
        cmd_valid  = 1'b1;
        cmd_m      = 16;
        cmd_k      = 16;
        cmd_n      = 16;
        cmd_a_addr = 32'h0;
        cmd_b_addr = 32'h100;
        cmd_c_addr = 32'h200;
        tick();
        cmd_valid = 1'b0;
        cyc = 0;
        while (!(bus_en && bus_rdwr && bus_addr == BASE + 32'd4) && cyc < 50) begin
            tick();
            cyc++;
        end
        chk("rst_mid.reach_wr_b", 64'(cyc < 50), 64'd1);
        rst = 1'b1;
        #1;
        chk("rst_mid.bus_en", 64'(bus_en), 64'd0);
        chk("rst_mid.busy", 64'(busy), 64'd0);
        tick();
        rst = 1'b0;
        tick();
        chk("rst_mid.ready", 64'(cmd_ready), 64'd1);
        chk("rst_mid.quiet", {bus_en, busy, bus_addr}, 34'd0);
        run_cmd(20, 20, 20, 32'h300, 32'h400, 32'h500, 0, 0, 1'b0, "after_rst", wb);

        // Randomized commands
        for (int r = 0; r < 6; r++) begin
            run_cmd(16'($urandom_range(1, 40)), 16'($urandom_range(1, 40)),
                    16'($urandom_range(1, 40)), $urandom, $urandom, $urandom,
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'b0,
                    $sformatf("rand%0d", r), wb);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
